// File: rtl/mcu_link_select_if.sv
// ============================================================================
// Module      : mcu_link_select_if
// Description : Pin-side and core-side SPI signals of the MCU link selector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mcu_link_select_if;
    logic int_sclk;
    logic int_csn;
    logic int_mosi;
    logic ext_sclk;
    logic ext_csn;
    logic ext_mosi;
    logic core_miso;
    logic core_intn;
    logic mcu_sclk;
    logic mcu_csn;
    logic mcu_mosi;
    logic int_miso;
    logic ext_miso;
    logic ext_intn;
    logic ext_active;
    logic switch_pulse;

    // Board/driver side
    modport master (
        output int_sclk, int_csn, int_mosi,
        output ext_sclk, ext_csn, ext_mosi,
        output core_miso, core_intn,
        input  mcu_sclk, mcu_csn, mcu_mosi,
        input  int_miso, ext_miso, ext_intn,
        input  ext_active, switch_pulse
    );

    // Selector side
    modport slave (
        input  int_sclk, int_csn, int_mosi,
        input  ext_sclk, ext_csn, ext_mosi,
        input  core_miso, core_intn,
        output mcu_sclk, mcu_csn, mcu_mosi,
        output int_miso, ext_miso, ext_intn,
        output ext_active, switch_pulse
    );
endinterface

`default_nettype wire

// File: rtl/mcu_link_select.sv
// ============================================================================
// Module      : mcu_link_select
// Description : Chooses the internal (BL616) or external (M0S) SPI link for
//               the core, with qualified detection and CSn-gated switchover.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcu_link_select #(
    parameter int SYNC_STAGES   = 2,
    parameter int DETECT_CYCLES = 4,
    parameter int REVERT_EN     = 0,
    parameter int TIMEOUT       = 16000000
) (
    input  logic              clk32,
    input  logic              reset_n,
    mcu_link_select_if.slave  link
);

    localparam logic [7:0]  c_DET_LAST = 8'(DETECT_CYCLES - 1);
    localparam logic [23:0] c_TO_LAST  = 24'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_INT    = 2'd0,
        S_PEND   = 2'd1,
        S_SETTLE = 2'd2,
        S_EXT    = 2'd3
    } state_t;

    state_t                  state_q;
    logic [SYNC_STAGES-1:0]  int_sync_q;
    logic [SYNC_STAGES-1:0]  ext_sync_q;
    logic [7:0]              det_cnt_q;
    logic [23:0]             to_cnt_q;
    logic                    sel_ext_q;
    logic                    gate_q;
    logic                    switch_pulse_q;

    logic                    w_int_cs_s;
    logic                    w_ext_cs_s;

    assign w_int_cs_s = int_sync_q[SYNC_STAGES-1];
    assign w_ext_cs_s = ext_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_INT;
            int_sync_q     <= '1;
            ext_sync_q     <= '1;
            det_cnt_q      <= '0;
            to_cnt_q       <= '0;
            sel_ext_q      <= 1'b0;
            gate_q         <= 1'b0;
            switch_pulse_q <= 1'b0;
        end else begin
            int_sync_q     <= {int_sync_q[SYNC_STAGES-2:0], link.int_csn};
            ext_sync_q     <= {ext_sync_q[SYNC_STAGES-2:0], link.ext_csn};
            switch_pulse_q <= 1'b0;

            case (state_q)
                S_INT: begin
                    if (w_ext_cs_s) begin
                        det_cnt_q <= '0;
                    end else if (det_cnt_q == c_DET_LAST) begin
                        det_cnt_q <= '0;
                        gate_q    <= 1'b1;
                        state_q   <= S_PEND;
                    end else begin
                        det_cnt_q <= det_cnt_q + 8'd1;
                    end
                end

                // Core already sees CSn high; wait out any internal frame.
                S_PEND: begin
                    if (w_int_cs_s) begin
                        state_q <= S_SETTLE;
                    end
                end

                S_SETTLE: begin
                    if (w_ext_cs_s) begin
                        gate_q         <= 1'b0;
                        sel_ext_q      <= 1'b1;
                        switch_pulse_q <= 1'b1;
                        to_cnt_q       <= '0;
                        state_q        <= S_EXT;
                    end
                end

                S_EXT: begin
                    // Idle counter saturates so a long busy internal CSn cannot wrap it.
                    if (!w_ext_cs_s) begin
                        to_cnt_q <= '0;
                    end else if (to_cnt_q != c_TO_LAST) begin
                        to_cnt_q <= to_cnt_q + 24'd1;
                    end
                    if ((REVERT_EN != 0) && (to_cnt_q == c_TO_LAST) && w_int_cs_s) begin
                        sel_ext_q      <= 1'b0;
                        switch_pulse_q <= 1'b1;
                        to_cnt_q       <= '0;
                        det_cnt_q      <= '0;
                        state_q        <= S_INT;
                    end
                end

                default: state_q <= S_INT;
            endcase
        end
    end

    // Data path is a pure mux off registered controls: no added SPI latency.
    assign link.mcu_sclk     = sel_ext_q ? link.ext_sclk : link.int_sclk;
    assign link.mcu_mosi     = sel_ext_q ? link.ext_mosi : link.int_mosi;
    assign link.mcu_csn      = gate_q ? 1'b1 : (sel_ext_q ? link.ext_csn : link.int_csn);

    assign link.int_miso     = link.core_miso;
    assign link.ext_miso     = link.core_miso;
    assign link.ext_intn     = link.core_intn;

    assign link.ext_active   = sel_ext_q;
    assign link.switch_pulse = switch_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_mcu_link_select.sv
// ============================================================================
// Module      : tb_mcu_link_select
// Description : Scoreboard bench for mcu_link_select (revert and terminal builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mcu_link_select;

    localparam int SYNC = 2;
    localparam int DET  = 4;
    localparam int TMO  = 100;

    localparam int M_INT  = 0;
    localparam int M_GATE = 1;
    localparam int M_EXT  = 2;
    localparam int M_DC   = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic int_sclk = 1'b0, int_csn = 1'b1, int_mosi = 1'b0;
    logic ext_sclk = 1'b0, ext_csn = 1'b1, ext_mosi = 1'b0;
    logic core_miso = 1'b0, core_intn = 1'b1;

    mcu_link_select_if la();
    mcu_link_select_if lb();

    assign la.int_sclk = int_sclk;   assign lb.int_sclk = int_sclk;
    assign la.int_csn  = int_csn;    assign lb.int_csn  = int_csn;
    assign la.int_mosi = int_mosi;   assign lb.int_mosi = int_mosi;
    assign la.ext_sclk = ext_sclk;   assign lb.ext_sclk = ext_sclk;
    assign la.ext_csn  = ext_csn;    assign lb.ext_csn  = ext_csn;
    assign la.ext_mosi = ext_mosi;   assign lb.ext_mosi = ext_mosi;
    assign la.core_miso = core_miso; assign lb.core_miso = core_miso;
    assign la.core_intn = core_intn; assign lb.core_intn = core_intn;

    mcu_link_select #(.SYNC_STAGES(SYNC), .DETECT_CYCLES(DET), .REVERT_EN(1), .TIMEOUT(TMO))
        u_dut_a (.clk32(clk), .reset_n(rst_n), .link(la.slave));

    mcu_link_select #(.SYNC_STAGES(SYNC), .DETECT_CYCLES(DET), .REVERT_EN(0), .TIMEOUT(TMO))
        u_dut_b (.clk32(clk), .reset_n(rst_n), .link(lb.slave));

    typedef struct {
        bit to_ext;
        int lo;
        int hi;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] frq[$];
    int n_tests = 0, n_fail = 0, cyc = 0, b_pulses = 0, last_rise = 0;
    int exp_mode = M_INT;
    bit chk_after = 1'b0;
    bit after_val = 1'b0;
    logic [7:0] sh = 8'h00;
    int nb = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic spi_xfer(input bit ext, input logic [7:0] b);
        if (ext) begin ext_sclk = 1'b0; ext_csn = 1'b0; end
        else     begin int_sclk = 1'b0; int_csn = 1'b0; end
        tick(1);
        for (int i = 7; i >= 0; i--) begin
            if (ext) ext_mosi = b[i]; else int_mosi = b[i];
            tick(1);
            if (ext) ext_sclk = 1'b1; else int_sclk = 1'b1;
            tick(1);
            if (ext) ext_sclk = 1'b0; else int_sclk = 1'b0;
        end
        tick(1);
        if (ext) ext_csn = 1'b1; else int_csn = 1'b1;
        last_rise = cyc;
        tick(1);
    endtask

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Background noise: MISO/INTn always, idle link's clock/data when selection is known
    initial forever begin
        @(posedge clk);
        #3;
        core_miso = 1'($urandom);
        core_intn = 1'($urandom);
        if (exp_mode == M_INT) begin
            ext_sclk = 1'($urandom);
            ext_mosi = 1'($urandom);
        end else if (exp_mode == M_EXT) begin
            int_sclk = 1'($urandom);
            int_mosi = 1'($urandom);
        end
    end

    // Frame monitor: collects bits the core would see, compares against queued bytes
    initial forever begin
        @(posedge la.mcu_sclk);
        if (la.mcu_csn === 1'b0) begin
            sh = {sh[6:0], la.mcu_mosi};
            nb++;
        end
    end

    initial forever begin
        @(negedge la.mcu_csn);
        nb = 0;
    end

    initial forever begin
        @(posedge la.mcu_csn);
        if (nb != 0) begin
            if (frq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_frame: got 0x%0h (%0d bits), expected none", sh, nb);
            end else begin
                chk("frame_byte", 32'(sh), 32'(frq.pop_front()));
                chk("frame_bits", nb, 8);
            end
        end
        nb = 0;
    end

    // Cycle monitor: fan-out, selection/gating, and switch-event scoreboard
    initial begin : mon
        ev_t e;
        forever begin
            @(negedge clk);
            chk("int_miso_fanout", la.int_miso, core_miso);
            chk("ext_miso_fanout", la.ext_miso, core_miso);
            chk("ext_intn_fanout", la.ext_intn, core_intn);
            if (lb.switch_pulse === 1'b1) b_pulses++;
            if (chk_after) begin
                chk("ext_active_after_switch", la.ext_active, after_val);
                chk_after = 1'b0;
            end
            if (la.switch_pulse === 1'b1) begin
                if (evq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_switch_pulse: got 1, expected 0 (cycle %0d)", cyc);
                end else begin
                    e = evq.pop_front();
                    chk("switch_pulse_in_window", 32'(cyc >= e.lo && cyc <= e.hi), 1);
                    chk_after = 1'b1;
                    after_val = e.to_ext;
                end
            end else if (evq.size() != 0 && cyc > evq[0].hi) begin
                n_tests++;
                n_fail++;
                $display("FAIL missed_switch_pulse: got none, expected by cycle %0d", evq[0].hi);
                void'(evq.pop_front());
            end
            case (exp_mode)
                M_INT: begin
                    chk("mcu_sclk_int", la.mcu_sclk, int_sclk);
                    chk("mcu_mosi_int", la.mcu_mosi, int_mosi);
                    chk("mcu_csn_int", la.mcu_csn, int_csn);
                    chk("ext_active_int", la.ext_active, 0);
                end
                M_GATE: begin
                    chk("mcu_csn_gated", la.mcu_csn, 1);
                    chk("ext_active_gated", la.ext_active, 0);
                end
                M_EXT: begin
                    chk("mcu_sclk_ext", la.mcu_sclk, ext_sclk);
                    chk("mcu_mosi_ext", la.mcu_mosi, ext_mosi);
                    chk("mcu_csn_ext", la.mcu_csn, ext_csn);
                    chk("ext_active_ext", la.ext_active, 1);
                end
                default: ;
            endcase
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t;
        int n;
        logic [7:0] b;

        tick(3);
        chk("reset_ext_active", la.ext_active, 0);
        chk("reset_switch_pulse", la.switch_pulse, 0);
        chk("reset_mcu_csn", la.mcu_csn, int_csn);
        rst_n = 1'b1;
        tick(3);

        // Internal transfers
        frq.push_back(8'hA5);
        spi_xfer(1'b0, 8'hA5);
        b = 8'($urandom);
        frq.push_back(b);
        spi_xfer(1'b0, b);
        tick(3);

        // Short external glitches must not qualify
        repeat (4) begin
            ext_csn = 1'b0;
            tick($urandom_range(1, DET - 1));
            ext_csn = 1'b1;
            tick($urandom_range(4, 8));
        end

        // Qualifying external activity with internal idle
        ext_csn = 1'b0;
        t = cyc;
        exp_mode = M_DC;
        wait_until(t + SYNC + DET + 1);
        exp_mode = M_GATE;
        wait_until(t + 10);
        ext_csn = 1'b1;
        evq.push_back('{1'b1, cyc + SYNC, cyc + SYNC + 2});
        exp_mode = M_DC;
        tick(6);
        exp_mode = M_EXT;
        chk("b_ext_active_qualified", lb.ext_active, 1);

        // External transfers, then idle timeout revert
        frq.push_back(8'h3C);
        spi_xfer(1'b1, 8'h3C);
        b = 8'($urandom);
        frq.push_back(b);
        spi_xfer(1'b1, b);
        n = last_rise;
        evq.push_back('{1'b0, n + SYNC + TMO - 2, n + SYNC + TMO + 2});
        wait_until(n + SYNC + TMO - 3);
        exp_mode = M_DC;
        wait_until(n + SYNC + TMO + 4);
        exp_mode = M_INT;
        chk("b_no_revert", lb.ext_active, 1);
        chk("b_pulse_count_mid", b_pulses, 1);
        tick(3);

        // Qualify while internal frame is open; external aborts during PEND
        int_csn = 1'b0;
        tick(3);
        ext_csn = 1'b0;
        t = cyc;
        exp_mode = M_DC;
        wait_until(t + SYNC + DET + 1);
        exp_mode = M_GATE;
        tick(5);
        ext_csn = 1'b1;
        tick(8);
        int_csn = 1'b1;
        evq.push_back('{1'b1, cyc + SYNC, cyc + SYNC + 3});
        exp_mode = M_DC;
        tick(7);
        exp_mode = M_EXT;
        frq.push_back(8'h3C);
        spi_xfer(1'b1, 8'h3C);

        // Revert postponed while internal CSn is low
        n = last_rise;
        tick(3);
        int_csn = 1'b0;
        wait_until(n + SYNC + TMO + 20);
        int_csn = 1'b1;
        evq.push_back('{1'b0, cyc + SYNC, cyc + SYNC + 2});
        exp_mode = M_DC;
        tick(6);
        exp_mode = M_INT;

        // Internal transfer, then reset while in SETTLE
        b = 8'($urandom);
        frq.push_back(b);
        spi_xfer(1'b0, b);
        tick(2);
        ext_csn = 1'b0;
        t = cyc;
        exp_mode = M_DC;
        wait_until(t + SYNC + DET + 4);
        exp_mode = M_GATE;
        int_csn = 1'b0;
        tick(2);
        exp_mode = M_DC;
        int_sclk = 1'b1;
        ext_sclk = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_mcu_csn", la.mcu_csn, 0);
        chk("reset_mid_mcu_sclk", la.mcu_sclk, 1);
        chk("reset_mid_ext_active", la.ext_active, 0);
        chk("reset_mid_switch_pulse", la.switch_pulse, 0);
        chk("reset_mid_b_ext_active", lb.ext_active, 0);
        ext_csn = 1'b1;
        int_csn = 1'b1;
        int_sclk = 1'b0;
        tick(2);
        rst_n = 1'b1;
        exp_mode = M_INT;
        tick(10);

        chk("b_pulse_count_total", b_pulses, 1);
        chk("switch_events_outstanding", evq.size(), 0);
        chk("frames_outstanding", frq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
